// File: rtl/whack_a_mole_core.sv
// Whack-a-mole game core: LFSR-picked moles, tick-timed windows and gaps,
// hit/miss scoring with lives and a difficulty level that shrinks the window.
module whack_a_mole_core #(
   parameter int N_MOLES = 4,
   parameter int SCORE_W = 8,
   parameter int WIN_INIT = 8,
   parameter int WIN_MIN = 2,
   parameter int LEVEL_STEP = 4,
   parameter int GAP_TICKS = 3,
   parameter int MAX_MISS = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               tick,
   input  logic [N_MOLES-1:0] btn,
   output logic [N_MOLES-1:0] mole,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic [3:0]         level,
   output logic               busy,
   output logic               game_over,
   output logic               hit_pulse,
   output logic               miss_pulse
);

   localparam int IDX_W  = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
   localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
   localparam int STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [N_MOLES-1:0] btn_q;
   logic [N_MOLES-1:0] mole_q, mole_d;
   logic [IDX_W-1:0]   prevIdx_q, prevIdx_d;
   logic               prevValid_q, prevValid_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         lives_q, lives_d;
   logic [3:0]         level_q, level_d;
   logic [3:0]         window_q, window_d;
   logic [3:0]         winCnt_q, winCnt_d;
   logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
   logic [STEP_W-1:0]  stepCnt_q, stepCnt_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               busy_q, busy_d;
   logic               over_q, over_d;

   logic [N_MOLES-1:0] btnEdge;
   logic               wrongEdge, rightEdge;
   logic               startEv, loadEv, hitEv, missEv;
   logic [IDX_W-1:0]   rawIdx, selIdx;
   logic [N_MOLES-1:0] moleSel;

   assign btnEdge   = btn & ~btn_q;
   assign wrongEdge = |(btnEdge & ~mole_q);
   assign rightEdge = |(btnEdge & mole_q);

   // Bumping a repeated index keeps consecutive moles distinct.
   always_comb begin
      rawIdx = IDX_W'(lfsr_q[7:0] % 8'(N_MOLES));
      selIdx = rawIdx;
      if (prevValid_q && (rawIdx == prevIdx_q)) begin
         selIdx = (rawIdx == IDX_W'(N_MOLES - 1)) ? '0 : rawIdx + 1'b1;
      end
      moleSel = {{(N_MOLES-1){1'b0}}, 1'b1} << selIdx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lfsr_q      <= LFSR_SEED;
         btn_q       <= '0;
         mole_q      <= '0;
         prevIdx_q   <= '0;
         prevValid_q <= 1'b0;
         score_q     <= '0;
         lives_q     <= '0;
         level_q     <= '0;
         window_q    <= 4'(WIN_INIT);
         winCnt_q    <= '0;
         gapCnt_q    <= '0;
         stepCnt_q   <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         busy_q      <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         btn_q       <= btn;
         mole_q      <= mole_d;
         prevIdx_q   <= prevIdx_d;
         prevValid_q <= prevValid_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         window_q    <= window_d;
         winCnt_q    <= winCnt_d;
         gapCnt_q    <= gapCnt_d;
         stepCnt_q   <= stepCnt_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         busy_q      <= busy_d;
         over_q      <= over_d;
      end
   end

   // A wrong press beats a correct one; a correct press beats an expiring tick.
   always_comb begin
      state_d = state_q;
      startEv = 1'b0;
      loadEv  = 1'b0;
      hitEv   = 1'b0;
      missEv  = 1'b0;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d = S_GAP;
               startEv = 1'b1;
            end
         end
         S_GAP: begin
            if (tick && (gapCnt_q <= GAP_W'(1))) begin
               state_d = S_UP;
               loadEv  = 1'b1;
            end
         end
         S_UP: begin
            if (wrongEdge || (!rightEdge && tick && (winCnt_q <= 4'd1))) begin
               missEv  = 1'b1;
               state_d = (lives_q <= 3'd1) ? S_OVER : S_GAP;
            end else if (rightEdge) begin
               hitEv   = 1'b1;
               state_d = S_GAP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      mole_d      = mole_q;
      prevIdx_d   = prevIdx_q;
      prevValid_d = prevValid_q;
      score_d     = score_q;
      lives_d     = lives_q;
      level_d     = level_q;
      window_d    = window_q;
      winCnt_d    = winCnt_q;
      gapCnt_d    = gapCnt_q;
      stepCnt_d   = stepCnt_q;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      busy_d      = (state_d == S_GAP) || (state_d == S_UP);
      over_d      = (state_d == S_OVER);

      if (startEv) begin
         mole_d    = '0;
         score_d   = '0;
         level_d   = '0;
         lives_d   = 3'(MAX_MISS);
         window_d  = 4'(WIN_INIT);
         gapCnt_d  = GAP_W'(GAP_TICKS);
         stepCnt_d = '0;
      end
      if ((state_q == S_GAP) && tick && !loadEv) begin
         gapCnt_d = gapCnt_q - 1'b1;
      end
      if (loadEv) begin
         mole_d      = moleSel;
         winCnt_d    = window_q;
         prevIdx_d   = selIdx;
         prevValid_d = 1'b1;
      end
      if ((state_q == S_UP) && tick && !hitEv && !missEv) begin
         winCnt_d = winCnt_q - 4'd1;
      end
      if (hitEv) begin
         hit_d    = 1'b1;
         mole_d   = '0;
         gapCnt_d = GAP_W'(GAP_TICKS);
         score_d  = (&score_q) ? score_q : score_q + 1'b1;
         // The shorter window takes effect at the next mole load.
         if (stepCnt_q == STEP_W'(LEVEL_STEP - 1)) begin
            stepCnt_d = '0;
            level_d   = (level_q == 4'd15) ? level_q : level_q + 4'd1;
            window_d  = (window_q > 4'(WIN_MIN)) ? window_q - 4'd1 : window_q;
         end else begin
            stepCnt_d = stepCnt_q + 1'b1;
         end
      end
      if (missEv) begin
         miss_d   = 1'b1;
         mole_d   = '0;
         gapCnt_d = GAP_W'(GAP_TICKS);
         lives_d  = lives_q - 3'd1;
      end
   end

   assign mole       = mole_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign level      = level_q;
   assign busy       = busy_q;
   assign game_over  = over_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule

// File: tb/tb_whack_a_mole_core.sv
// Directed bench for whack_a_mole_core: default build plus small-score,
// two-mole fast-levelling and eight-mole builds sharing clock and controls.
module tb_whack_a_mole_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, tick;

   logic [3:0] btn0, mole0;
   logic [7:0] score0;
   logic [2:0] lives0;
   logic [3:0] level0;
   logic       busy0, over0, hit0, miss0;

   logic [3:0] btn1, mole1;
   logic [2:0] score1;
   logic [2:0] lives1;
   logic [3:0] level1;
   logic       busy1, over1, hit1, miss1;

   logic [1:0] btn2, mole2;
   logic [7:0] score2;
   logic [2:0] lives2;
   logic [3:0] level2;
   logic       busy2, over2, hit2, miss2;

   logic [7:0] btn3, mole3;
   logic [7:0] score3;
   logic [2:0] lives3;
   logic [3:0] level3;
   logic       busy3, over3, hit3, miss3;

   int total  = 0;
   int passed = 0;

   whack_a_mole_core dut0 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .btn(btn0),
      .mole(mole0), .score(score0), .lives(lives0), .level(level0),
      .busy(busy0), .game_over(over0), .hit_pulse(hit0), .miss_pulse(miss0));

   whack_a_mole_core #(.SCORE_W(3)) dut1 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .btn(btn1),
      .mole(mole1), .score(score1), .lives(lives1), .level(level1),
      .busy(busy1), .game_over(over1), .hit_pulse(hit1), .miss_pulse(miss1));

   whack_a_mole_core #(.N_MOLES(2), .WIN_INIT(4), .WIN_MIN(2), .LEVEL_STEP(1)) dut2 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .btn(btn2),
      .mole(mole2), .score(score2), .lives(lives2), .level(level2),
      .busy(busy2), .game_over(over2), .hit_pulse(hit2), .miss_pulse(miss2));

   whack_a_mole_core #(.N_MOLES(8)) dut3 (
      .clk(clk), .rst(rst), .start(start), .tick(tick), .btn(btn3),
      .mole(mole3), .score(score3), .lives(lives3), .level(level3),
      .busy(busy3), .game_over(over3), .hit_pulse(hit3), .miss_pulse(miss3));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tickCyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic waitMole0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (mole0 != 4'b0) ok = 1'b1;
         else tickCyc();
      end
      total++; if (!ok) $display("[TB] FAIL wait_mole0: no mole within 40 ticks, got %b want one-hot", mole0); else passed++;
   endtask

   task automatic waitAllLit(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (mole1 != 4'b0 && mole2 != 2'b0 && mole3 != 8'b0) ok = 1'b1;
         else tickCyc();
      end
      total++; if (!ok) $display("[TB] FAIL wait_all_lit: got %b %b %b want all lit", mole1, mole2, mole3); else passed++;
   endtask

   task automatic countToMiss0(output int n);
      n = 0;
      for (int k = 1; k <= 20 && n == 0; k++) begin
         tickCyc();
         if (miss0) n = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tick = 1'b0;
      btn0 = '0; btn1 = '0; btn2 = '0; btn3 = '0;
      cyc(); cyc();
      rst = 1'b0;
      total++; if (mole0 !== 4'b0) $display("[TB] FAIL reset_mole: got %b want 0000", mole0); else passed++;
      total++; if (score0 !== 8'd0) $display("[TB] FAIL reset_score: got %0d want 0", score0); else passed++;
      total++; if (lives0 !== 3'd0) $display("[TB] FAIL reset_lives: got %0d want 0", lives0); else passed++;
      total++; if (level0 !== 4'd0) $display("[TB] FAIL reset_level: got %0d want 0", level0); else passed++;
      total++; if (busy0 !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy0); else passed++;
      total++; if (over0 !== 1'b0) $display("[TB] FAIL reset_over: got %b want 0", over0); else passed++;
      total++; if ({hit0, miss0} !== 2'b00) $display("[TB] FAIL reset_pulses: got %b want 00", {hit0, miss0}); else passed++;
   endtask

   task automatic test_start();
      start = 1'b1; cyc(); start = 1'b0;
      total++; if (busy0 !== 1'b1) $display("[TB] FAIL start_busy: got %b want 1", busy0); else passed++;
      total++; if (lives0 !== 3'd3) $display("[TB] FAIL start_lives: got %0d want 3", lives0); else passed++;
      total++; if (score0 !== 8'd0) $display("[TB] FAIL start_score: got %0d want 0", score0); else passed++;
      for (int t = 1; t <= 3; t++) begin
         cyc(); cyc(); cyc();
         tickCyc();
         if (t < 3) begin
            total++; if (mole0 !== 4'b0) $display("[TB] FAIL gap_mole_tick%0d: got %b want 0000", t, mole0); else passed++;
         end else begin
            total++; if (!$onehot(mole0)) $display("[TB] FAIL gap_mole_lit: got %b want one-hot", mole0); else passed++;
         end
      end
   endtask

   task automatic test_hits();
      logic [3:0] prev;
      bit ok;
      int n;
      prev = mole0;
      for (int h = 0; h < 4; h++) begin
         if (h > 0) begin
            waitMole0(ok);
            total++; if (mole0 === prev) $display("[TB] FAIL hit_repeat: got %b want not %b", mole0, prev); else passed++;
         end
         prev = mole0;
         btn0 = mole0; cyc();
         total++; if (hit0 !== 1'b1) $display("[TB] FAIL hit_pulse%0d: got %b want 1", h, hit0); else passed++;
         total++; if (mole0 !== 4'b0) $display("[TB] FAIL hit_mole_clear%0d: got %b want 0000", h, mole0); else passed++;
         btn0 = '0; cyc();
         total++; if (hit0 !== 1'b0) $display("[TB] FAIL hit_pulse_width%0d: got %b want 0", h, hit0); else passed++;
      end
      total++; if (score0 !== 8'd4) $display("[TB] FAIL hits_score: got %0d want 4", score0); else passed++;
      total++; if (level0 !== 4'd1) $display("[TB] FAIL hits_level: got %0d want 1", level0); else passed++;
      total++; if (lives0 !== 3'd3) $display("[TB] FAIL hits_lives: got %0d want 3", lives0); else passed++;
      waitMole0(ok);
      countToMiss0(n);
      total++; if (n !== 7) $display("[TB] FAIL level1_window: got %0d ticks want 7", n); else passed++;
      total++; if (lives0 !== 3'd2) $display("[TB] FAIL level1_lives: got %0d want 2", lives0); else passed++;
   endtask

   task automatic test_start_ignored();
      start = 1'b1; cyc(); start = 1'b0; cyc();
      total++; if (lives0 !== 3'd2) $display("[TB] FAIL busy_start_lives: got %0d want 2", lives0); else passed++;
      total++; if (score0 !== 8'd4) $display("[TB] FAIL busy_start_score: got %0d want 4", score0); else passed++;
      btn0 = 4'b1111; cyc(); btn0 = '0; cyc();
      total++; if ({score0, lives0} !== {8'd4, 3'd2}) $display("[TB] FAIL gap_press: got score %0d lives %0d want 4 2", score0, lives0); else passed++;
   endtask

   task automatic test_misses();
      bit ok;
      int n;
      rst = 1'b1; cyc(); rst = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int m = 0; m < 3; m++) begin
         waitMole0(ok);
         countToMiss0(n);
         total++; if (n !== 8) $display("[TB] FAIL miss_window%0d: got %0d ticks want 8", m, n); else passed++;
         total++; if (lives0 !== 3'(2 - m)) $display("[TB] FAIL miss_lives%0d: got %0d want %0d", m, lives0, 2 - m); else passed++;
      end
      total++; if (over0 !== 1'b1) $display("[TB] FAIL over_flag: got %b want 1", over0); else passed++;
      total++; if (mole0 !== 4'b0) $display("[TB] FAIL over_mole: got %b want 0000", mole0); else passed++;
      total++; if (busy0 !== 1'b0) $display("[TB] FAIL over_busy: got %b want 0", busy0); else passed++;
      cyc();
      total++; if (miss0 !== 1'b0) $display("[TB] FAIL miss_pulse_width: got %b want 0", miss0); else passed++;
      btn0 = 4'b1111; tickCyc(); btn0 = '0; tickCyc(); tickCyc();
      total++; if ({over0, lives0, score0} !== {1'b1, 3'd0, 8'd0}) $display("[TB] FAIL over_hold: got over %b lives %0d score %0d want 1 0 0", over0, lives0, score0); else passed++;
   endtask

   task automatic test_simultaneous();
      bit ok;
      start = 1'b1; cyc(); start = 1'b0;
      total++; if ({over0, lives0} !== {1'b0, 3'd3}) $display("[TB] FAIL restart: got over %b lives %0d want 0 3", over0, lives0); else passed++;
      waitMole0(ok);
      btn0 = mole0 | {mole0[2:0], mole0[3]}; cyc();
      total++; if ({hit0, miss0} !== 2'b01) $display("[TB] FAIL both_pulses: got hit %b miss %b want 0 1", hit0, miss0); else passed++;
      total++; if (score0 !== 8'd0) $display("[TB] FAIL both_score: got %0d want 0", score0); else passed++;
      total++; if (lives0 !== 3'd2) $display("[TB] FAIL both_lives: got %0d want 2", lives0); else passed++;
      btn0 = '0; cyc();
   endtask

   task automatic test_expiry_edge();
      bit ok;
      waitMole0(ok);
      for (int i = 0; i < 7; i++) tickCyc();
      total++; if (mole0 === 4'b0 || lives0 !== 3'd2) $display("[TB] FAIL pre_expiry: got mole %b lives %0d want lit 2", mole0, lives0); else passed++;
      btn0 = mole0; tick = 1'b1; cyc(); tick = 1'b0;
      total++; if ({hit0, miss0} !== 2'b10) $display("[TB] FAIL expiry_hit: got hit %b miss %b want 1 0", hit0, miss0); else passed++;
      total++; if ({score0, lives0} !== {8'd1, 3'd2}) $display("[TB] FAIL expiry_score: got score %0d lives %0d want 1 2", score0, lives0); else passed++;
      btn0 = '0; cyc();
   endtask

   task automatic test_params();
      logic [1:0] prev2;
      logic [7:0] prev3;
      bit ok;
      int n1, n2;
      rst = 1'b1; cyc(); rst = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      prev2 = '0; prev3 = '0;
      for (int i = 0; i < 10; i++) begin
         waitAllLit(ok);
         total++; if (!$onehot(mole2) || mole2 === prev2) $display("[TB] FAIL n2_repeat%0d: got %b want one-hot not %b", i, mole2, prev2); else passed++;
         total++; if (!$onehot(mole3) || mole3 === prev3) $display("[TB] FAIL n8_repeat%0d: got %b want one-hot not %b", i, mole3, prev3); else passed++;
         prev2 = mole2; prev3 = mole3;
         btn1 = mole1; btn2 = mole2; btn3 = mole3; cyc();
         total++; if ({hit1, hit2, hit3} !== 3'b111) $display("[TB] FAIL param_hits%0d: got %b want 111", i, {hit1, hit2, hit3}); else passed++;
         btn1 = '0; btn2 = '0; btn3 = '0; cyc();
      end
      total++; if (score1 !== 3'd7) $display("[TB] FAIL sat_score: got %0d want 7", score1); else passed++;
      total++; if (level1 !== 4'd2) $display("[TB] FAIL sat_level: got %0d want 2", level1); else passed++;
      total++; if (score2 !== 8'd10) $display("[TB] FAIL fast_score: got %0d want 10", score2); else passed++;
      total++; if (level2 !== 4'd10) $display("[TB] FAIL fast_level: got %0d want 10", level2); else passed++;
      waitAllLit(ok);
      n1 = 0; n2 = 0;
      for (int k = 1; k <= 20 && (n1 == 0 || n2 == 0); k++) begin
         tickCyc();
         if (miss1 && n1 == 0) n1 = k;
         if (miss2 && n2 == 0) n2 = k;
      end
      total++; if (n1 !== 6) $display("[TB] FAIL level2_window: got %0d ticks want 6", n1); else passed++;
      total++; if (n2 !== 2) $display("[TB] FAIL floor_window: got %0d ticks want 2", n2); else passed++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      rst = 1'b1; cyc(); rst = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      waitMole0(ok);
      btn0 = mole0; rst = 1'b1; start = 1'b1; cyc(); rst = 1'b0; start = 1'b0; btn0 = '0;
      total++; if (mole0 !== 4'b0) $display("[TB] FAIL midrst_mole: got %b want 0000", mole0); else passed++;
      total++; if ({busy0, over0, hit0, miss0} !== 4'b0000) $display("[TB] FAIL midrst_flags: got %b want 0000", {busy0, over0, hit0, miss0}); else passed++;
      total++; if ({score0, lives0, level0} !== 15'd0) $display("[TB] FAIL midrst_counts: got score %0d lives %0d level %0d want 0 0 0", score0, lives0, level0); else passed++;
   endtask

   initial begin
      test_reset();
      test_start();
      test_hits();
      test_start_ignored();
      test_misses();
      test_simultaneous();
      test_expiry_edge();
      test_params();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
